// File: rtl/fpga_pkg.sv
// Shared defaults for the LED / aux-clock-check design.
//   CntWDefault    : main blink counter width (LEDR0 = counter MSB)
//   AuxCntWDefault : width of the detected-aux-rise counter (LEDR1 = its MSB)
//   AliveWDefault  : aux activity timer width; timeout = 2**AliveWDefault-1 cycles
package fpga_pkg;

  localparam int unsigned CntWDefault    = 26;
  localparam int unsigned AuxCntWDefault = 24;
  localparam int unsigned AliveWDefault  = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bit.
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low reset, clears both stages to 0
//   d_i    : asynchronous input
//   q_o    : d_i delayed by two rising edges of clk_i
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fpga_top.sv
// Board-level top of the LED / clock-check design. Everything runs on fpga_CLK;
// the auxiliary oscillator output is only ever sampled as data.
//   fpga_CLK         : main 50 MHz clock
//   fpga_NRST        : asynchronous active-low reset
//   fpga_CLK_AUX     : aux oscillator output, sampled through a synchronizer
//   fpga_SW0         : holds the main counter cleared while 1
//   fpga_SW1         : aux oscillator enable request
//   fpga_SEL_CLK_AUX : aux oscillator enable to the board (= fpga_SW1)
//   fpga_LEDR0       : main heartbeat (main counter MSB)
//   fpga_LEDR1       : aux heartbeat (detected-rise counter MSB)
//   fpga_LEDR2       : aux alive indicator
//   fpga_LEDR3       : synchronized SW0 echo
module fpga_top
  import fpga_pkg::*;
#(
  parameter int unsigned CNT_W     = CntWDefault,
  parameter int unsigned AUX_CNT_W = AuxCntWDefault,
  parameter int unsigned ALIVE_W   = AliveWDefault
) (
  input  logic fpga_CLK,
  input  logic fpga_NRST,
  input  logic fpga_CLK_AUX,
  input  logic fpga_SW0,
  input  logic fpga_SW1,
  output logic fpga_SEL_CLK_AUX,
  output logic fpga_LEDR0,
  output logic fpga_LEDR1,
  output logic fpga_LEDR2,
  output logic fpga_LEDR3
);

  // Not reset-gated so the oscillator can be started while the core is held in reset.
  assign fpga_SEL_CLK_AUX = fpga_SW1;

  logic sw0_s;
  logic sw1_s;
  logic aux_s;

  sync2 u_sync_sw0 (
    .clk_i  (fpga_CLK),
    .rst_ni (fpga_NRST),
    .d_i    (fpga_SW0),
    .q_o    (sw0_s)
  );

  // SW1 is synchronized for completeness of the board interface; no logic consumes it yet.
  sync2 u_sync_sw1 (
    .clk_i  (fpga_CLK),
    .rst_ni (fpga_NRST),
    .d_i    (fpga_SW1),
    .q_o    (sw1_s)
  );

  sync2 u_sync_aux (
    .clk_i  (fpga_CLK),
    .rst_ni (fpga_NRST),
    .d_i    (fpga_CLK_AUX),
    .q_o    (aux_s)
  );

  logic                 unused_sw1;
  assign unused_sw1 = sw1_s;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 aux_prev_q;
  logic [AUX_CNT_W-1:0] aux_cnt_q, aux_cnt_d;
  logic [ALIVE_W-1:0]   alive_q, alive_d;
  logic                 led0_q, led1_q, led2_q, led3_q;

  logic aux_rise;
  logic aux_toggle;

  // The aux input is aliased at 50 MHz sampling; only the edges actually seen are counted.
  assign aux_rise   = aux_s & ~aux_prev_q;
  assign aux_toggle = aux_s ^ aux_prev_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (sw0_s) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    aux_cnt_d = aux_cnt_q;
    if (aux_rise) begin
      aux_cnt_d = aux_cnt_q + AUX_CNT_W'(1);
    end
  end

  // Reload wins over decrement; the timer parks at 0 once the aux input goes quiet.
  always_comb begin
    alive_d = alive_q;
    if (aux_toggle) begin
      alive_d = '1;
    end else if (alive_q != '0) begin
      alive_d = alive_q - ALIVE_W'(1);
    end
  end

  always_ff @(posedge fpga_CLK or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      cnt_q      <= '0;
      aux_prev_q <= 1'b0;
      aux_cnt_q  <= '0;
      alive_q    <= '0;
      led0_q     <= 1'b0;
      led1_q     <= 1'b0;
      led2_q     <= 1'b0;
      led3_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      aux_prev_q <= aux_s;
      aux_cnt_q  <= aux_cnt_d;
      alive_q    <= alive_d;
      led0_q     <= cnt_q[CNT_W-1];
      led1_q     <= aux_cnt_q[AUX_CNT_W-1];
      led2_q     <= (alive_q != '0);
      led3_q     <= sw0_s;
    end
  end

  assign fpga_LEDR0 = led0_q;
  assign fpga_LEDR1 = led1_q;
  assign fpga_LEDR2 = led2_q;
  assign fpga_LEDR3 = led3_q;

endmodule

// File: tb/tb_fpga_top.sv
`timescale 1ns/1ps
module tb_fpga_top;

  logic fpga_CLK;
  logic fpga_NRST;
  logic fpga_CLK_AUX;
  logic fpga_SW0;
  logic fpga_SW1;
  logic fpga_SEL_CLK_AUX;
  logic fpga_LEDR0, fpga_LEDR1, fpga_LEDR2, fpga_LEDR3;

  fpga_top #(
    .CNT_W   (8),
    .ALIVE_W (6)
  ) dut (
    .fpga_CLK         (fpga_CLK),
    .fpga_NRST        (fpga_NRST),
    .fpga_CLK_AUX     (fpga_CLK_AUX),
    .fpga_SW0         (fpga_SW0),
    .fpga_SW1         (fpga_SW1),
    .fpga_SEL_CLK_AUX (fpga_SEL_CLK_AUX),
    .fpga_LEDR0       (fpga_LEDR0),
    .fpga_LEDR1       (fpga_LEDR1),
    .fpga_LEDR2       (fpga_LEDR2),
    .fpga_LEDR3       (fpga_LEDR3)
  );

  typedef struct packed {
    logic [3:0]  leds;
    logic [7:0]  cnt;
    logic [23:0] acnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  initial begin
    fpga_CLK = 1'b0;
    forever #10 fpga_CLK = ~fpga_CLK;
  end

  // Aux oscillator: 18.5 ns half period while enabled. The 0.25 ns start offset keeps
  // every aux transition off the integer grid, so it never coincides with a clock edge.
  initial begin
    fpga_CLK_AUX = 1'b0;
    forever begin
      if (fpga_SEL_CLK_AUX) begin
        #0.25;
        while (fpga_SEL_CLK_AUX) begin
          #18.5;
          if (fpga_SEL_CLK_AUX) fpga_CLK_AUX = ~fpga_CLK_AUX;
        end
        fpga_CLK_AUX = 1'b0;
      end else begin
        @(posedge fpga_SEL_CLK_AUX);
      end
    end
  end

  // Reference model: input samples per clock edge, plus the edge indices of the last
  // counter clear and the last detected aux toggle. Edge 0 is the reset state.
  bit          sw_smp[$];
  bit          aux_smp[$];
  int          n;
  int          last_clear;
  int          last_tog;
  logic [23:0] aux_total;

  function automatic bit sw_at(int k);
    if (k < 1 || k > sw_smp.size()) return 1'b0;
    return sw_smp[k-1];
  endfunction

  function automatic bit aux_at(int k);
    if (k < 1 || k > aux_smp.size()) return 1'b0;
    return aux_smp[k-1];
  endfunction

  initial begin
    exp_t e;
    int   m;
    n = 0; last_clear = 0; last_tog = -1000; aux_total = '0;
    forever begin
      @(posedge fpga_CLK);
      if (!fpga_NRST) begin
        n = 0;
        sw_smp.delete();
        aux_smp.delete();
        last_clear = 0;
        last_tog   = -1000;
        aux_total  = '0;
        exp_q.push_back('0);
      end else begin
        m = n;
        // LEDs after this edge reflect model state after the previous edge.
        e.leds[0] = (((m - last_clear) % 256) >= 128);
        e.leds[1] = aux_total[23];
        e.leds[2] = ((m - last_tog) < 63);
        e.leds[3] = sw_at(m - 1);
        n = n + 1;
        sw_smp.push_back(fpga_SW0);
        aux_smp.push_back(fpga_CLK_AUX);
        // Synchronized value seen at edge n is the sample taken two edges earlier.
        if (sw_at(n - 2)) last_clear = n;
        if (aux_at(n - 2) != aux_at(n - 3)) last_tog = n;
        if (aux_at(n - 2) && !aux_at(n - 3)) aux_total = aux_total + 24'd1;
        e.cnt  = 8'((n - last_clear) % 256);
        e.acnt = aux_total;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: every clock presents a fresh output set; compare on the falling edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge fpga_CLK);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {fpga_LEDR3, fpga_LEDR2, fpga_LEDR1, fpga_LEDR0, dut.cnt_q, dut.aux_cnt_q};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL cycle_check t=%0t got leds=%b cnt=%0d acnt=%0d, expected leds=%b cnt=%0d acnt=%0d",
                   $time, got.leds, got.cnt, got.acnt, e.leds, e.cnt, e.acnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, expv);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge fpga_CLK);
  endtask

  task automatic check_leds_zero(input string name);
    check(name, {28'd0, fpga_LEDR3, fpga_LEDR2, fpga_LEDR1, fpga_LEDR0}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge fpga_CLK);
    #5 fpga_NRST = 1'b0;
    #1;
    check_leds_zero("async_reset_leds");
    check("async_reset_cnt", {24'd0, dut.cnt_q}, 32'd0);
    check("reset_sel_follows_sw1", {31'd0, fpga_SEL_CLK_AUX}, {31'd0, fpga_SW1});
    cycles(3);
    fpga_NRST = 1'b1;
  endtask

  initial begin
    fpga_NRST = 1'b0;
    fpga_SW0  = 1'b0;
    fpga_SW1  = 1'b0;
    cycles(3);
    check("sel_off_in_reset", {31'd0, fpga_SEL_CLK_AUX}, 32'd0);
    check_leds_zero("leds_in_reset");
    fpga_SW1 = 1'b1;
    #0;
    check("sel_on_in_reset", {31'd0, fpga_SEL_CLK_AUX}, 32'd1);
    cycles(5);
    check_leds_zero("leds_in_reset_aux_running");

    // Heartbeat and aux activity with the oscillator running.
    fpga_NRST = 1'b1;
    cycles(300);
    // Oscillator stopped: alive indicator must time out, aux count freezes.
    fpga_SW1 = 1'b0;
    #1;
    check("sel_off_run", {31'd0, fpga_SEL_CLK_AUX}, 32'd0);
    cycles(100);
    check("alive_timed_out", {31'd0, fpga_LEDR2}, 32'd0);
    // Counter clear held for 100 cycles, then released.
    fpga_SW0 = 1'b1;
    cycles(100);
    check("sw0_echo", {31'd0, fpga_LEDR3}, 32'd1);
    check("cnt_held_zero", {24'd0, dut.cnt_q}, 32'd0);
    fpga_SW0 = 1'b0;
    cycles(50);
    check("sw0_echo_off", {31'd0, fpga_LEDR3}, 32'd0);

    // Randomized switch activity with occasional mid-run resets.
    for (int i = 0; i < 40; i++) begin
      fpga_SW0 = 1'($urandom_range(0, 3) == 0);
      fpga_SW1 = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 80));
      if (i == 15 || i == 30) pulse_reset();
    end

    // Long free run to see the heartbeat wrap again.
    fpga_SW0 = 1'b0;
    fpga_SW1 = 1'b1;
    cycles(300);
    fpga_SW1 = 1'b0;
    cycles(80);
    check("final_alive_off", {31'd0, fpga_LEDR2}, 32'd0);
    cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
